// File: rtl/seg_step_scheduler.sv
// Seven-segment step sequencer: walks a position counter at a speed-selected
// rate, issues one segment-fire request per step and paces a periodic fade tick.
module seg_step_scheduler #(
  parameter int unsigned STEP_WIDTH = 22,
  parameter int unsigned FADE_WIDTH = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] speed,
  input  logic       direction,
  output logic       fire_valid,
  output logic [2:0] fire_seg,
  input  logic       fire_ready,
  output logic       fade_tick,
  output logic [2:0] step_pos
);

  typedef enum logic [1:0] {IDLE, RUN, ISSUE} state_t;

  state_t                state, state_nx;
  logic [STEP_WIDTH-1:0] step_cnt, step_cnt_nx;
  logic [STEP_WIDTH-1:0] tc;
  logic [FADE_WIDTH-1:0] fade_cnt, fade_cnt_nx;
  logic [2:0]            speed_r;
  logic                  direction_r;
  logic [2:0]            step_pos_nx;
  logic                  fire_valid_nx;
  logic [2:0]            fire_seg_nx;
  logic                  fade_tick_nx;

  // Upper three bits of the terminal count shrink as speed rises.
  assign tc = {~speed_r, {(STEP_WIDTH-3){1'b1}}};

  function automatic logic [2:0] seg_map(input logic [2:0] pos);
    case (pos)
      3'd0:    seg_map = 3'd0;
      3'd1:    seg_map = 3'd1;
      3'd2:    seg_map = 3'd6;
      3'd3:    seg_map = 3'd4;
      3'd4:    seg_map = 3'd3;
      3'd5:    seg_map = 3'd2;
      3'd6:    seg_map = 3'd6;
      default: seg_map = 3'd5;
    endcase
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_nx    = state;
    step_cnt_nx = step_cnt;
    step_pos_nx = step_pos;
    case (state)
      IDLE: begin
        step_cnt_nx = '0;
        if (enable) state_nx = ISSUE;
      end
      RUN: begin
        if (!enable) begin
          state_nx    = IDLE;
          step_cnt_nx = '0;
        end else if (step_cnt >= tc) begin
          // >= so a lowered tc still wraps on the following cycle.
          state_nx    = ISSUE;
          step_cnt_nx = '0;
          step_pos_nx = direction_r ? step_pos + 3'd1 : step_pos - 3'd1;
        end else begin
          step_cnt_nx = step_cnt + STEP_WIDTH'(1);
        end
      end
      ISSUE: begin
        if (fire_ready) state_nx = enable ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (state == IDLE || state_nx == IDLE) fade_cnt_nx = '0;
    else                                   fade_cnt_nx = fade_cnt + FADE_WIDTH'(1);
    fade_tick_nx  = &fade_cnt_nx;
    fire_valid_nx = (state_nx == ISSUE);
    fire_seg_nx   = fire_valid_nx ? seg_map(step_pos_nx) : 3'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      step_cnt    <= '0;
      fade_cnt    <= '0;
      step_pos    <= 3'd0;
      fire_valid  <= 1'b0;
      fire_seg    <= 3'd0;
      fade_tick   <= 1'b0;
      speed_r     <= 3'd0;
      direction_r <= 1'b0;
    end else begin
      state       <= state_nx;
      step_cnt    <= step_cnt_nx;
      fade_cnt    <= fade_cnt_nx;
      step_pos    <= step_pos_nx;
      fire_valid  <= fire_valid_nx;
      fire_seg    <= fire_seg_nx;
      fade_tick   <= fade_tick_nx;
      speed_r     <= speed;
      direction_r <= direction;
    end
  end

endmodule

// File: tb/tb_seg_step_scheduler.sv
// Directed bench for seg_step_scheduler with STEP_WIDTH=6, FADE_WIDTH=4.
module tb_seg_step_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] speed;
  logic       direction;
  logic       fire_valid;
  logic [2:0] fire_seg;
  logic       fire_ready;
  logic       fade_tick;
  logic [2:0] step_pos;

  int vectors = 0;
  int errs    = 0;

  seg_step_scheduler #(.STEP_WIDTH(6), .FADE_WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .speed     (speed),
    .direction (direction),
    .fire_valid(fire_valid),
    .fire_seg  (fire_seg),
    .fire_ready(fire_ready),
    .fade_tick (fade_tick),
    .step_pos  (step_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count negedges until fire_valid is seen high (at least one step, bounded).
  task automatic wait_fire(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fire_valid && n < max);
  endtask

  initial begin
    int n;
    int tick_idx[$];
    logic [2:0] fwd_seg [8];
    fwd_seg = '{3'd1, 3'd6, 3'd4, 3'd3, 3'd2, 3'd6, 3'd5, 3'd0};

    reset = 1'b0; enable = 1'b1; fire_ready = 1'b1; speed = 3'd7; direction = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_fire_valid", 32'(fire_valid), 0);
    chk("rst_fire_seg",   32'(fire_seg),   0);
    chk("rst_step_pos",   32'(step_pos),   0);
    chk("rst_fade_tick",  32'(fade_tick),  0);

    // First fire right after release, no step delay.
    reset = 1'b1;
    @(negedge clk);
    chk("first_fire_valid", 32'(fire_valid), 1);
    chk("first_fire_seg",   32'(fire_seg),   0);
    chk("first_step_pos",   32'(step_pos),   0);

    // Forward sequence at speed 7: 8 RUN + 1 ISSUE cycles between fires.
    for (int i = 0; i < 8; i++) begin
      wait_fire(40, n);
      chk($sformatf("fwd_spacing_%0d", i), 32'(n), 9);
      chk($sformatf("fwd_seg_%0d", i), 32'(fire_seg), 32'(fwd_seg[i]));
      chk($sformatf("fwd_pos_%0d", i), 32'(step_pos), 32'((i + 1) % 8));
    end

    // Stall in ISSUE: outputs frozen, fade_tick keeps a 16-cycle period.
    fire_ready = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk("stall_fire_valid", 32'(fire_valid), 1);
      chk("stall_fire_seg",   32'(fire_seg),   0);
      chk("stall_step_pos",   32'(step_pos),   0);
      if (fade_tick) tick_idx.push_back(i);
    end
    chk("stall_tick_count", 32'(tick_idx.size()), 2);
    if (tick_idx.size() >= 2) chk("stall_tick_period", 32'(tick_idx[1] - tick_idx[0]), 16);
    fire_ready = 1'b1;
    wait_fire(40, n);
    chk("post_stall_spacing", 32'(n), 9);
    chk("post_stall_seg",     32'(fire_seg), 1);
    chk("post_stall_pos",     32'(step_pos), 1);

    // Reverse: 1 -> 0 -> 7.
    direction = 1'b0;
    wait_fire(40, n);
    chk("rev0_spacing", 32'(n), 9);
    chk("rev0_pos",     32'(step_pos), 0);
    chk("rev0_seg",     32'(fire_seg), 0);
    wait_fire(40, n);
    chk("rev7_spacing", 32'(n), 9);
    chk("rev7_pos",     32'(step_pos), 7);
    chk("rev7_seg",     32'(fire_seg), 5);

    // Drop enable mid-ISSUE; request must survive until the handshake.
    enable = 1'b0; fire_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_fire_valid", 32'(fire_valid), 1);
      chk("hold_fire_seg",   32'(fire_seg),   5);
    end
    fire_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_fire_valid", 32'(fire_valid), 0);
      chk("idle_fire_seg",   32'(fire_seg),   0);
      chk("idle_fade_tick",  32'(fade_tick),  0);
      chk("idle_step_pos",   32'(step_pos),   7);
    end

    // Re-enable slow, then speed up mid-step: count already past new tc.
    speed = 3'd0; direction = 1'b1; enable = 1'b1;
    @(negedge clk);
    chk("reen_fire_valid", 32'(fire_valid), 1);
    chk("reen_fire_seg",   32'(fire_seg),   5);
    repeat (20) @(negedge clk);
    chk("slow_no_fire", 32'(fire_valid), 0);
    speed = 3'd7;
    wait_fire(100, n);
    chk("ge_wrap_latency", 32'(n), 2);
    chk("ge_wrap_pos",     32'(step_pos), 0);
    chk("ge_wrap_seg",     32'(fire_seg), 0);

    // Asynchronous reset between edges while a request is pending.
    fire_ready = 1'b0;
    @(negedge clk);
    chk("pre_arst_fire_valid", 32'(fire_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_fire_valid", 32'(fire_valid), 0);
    chk("arst_fire_seg",   32'(fire_seg),   0);
    chk("arst_step_pos",   32'(step_pos),   0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/seg_step_scheduler.md
SEG_STEP_SCHEDULER -- requirements
Module: seg_step_scheduler

Interface
REQ-001 Parameter STEP_WIDTH, default 22: step timer width in bits.
REQ-002 Parameter FADE_WIDTH, default 20: fade timer width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: run request.
REQ-006 The block SHALL have port speed, input, 3 bits: step-rate select; a higher value steps faster.
REQ-007 The block SHALL have port direction, input, 1 bit: 1 = forward, 0 = reverse.
REQ-008 The block SHALL have port fire_valid, output, 1 bit: segment-fire request to the fade engine.
REQ-009 The block SHALL have port fire_seg, output, 3 bits: segment index 0-6 to fire.
REQ-010 The block SHALL have port fire_ready, input, 1 bit: the fade engine accepts the request.
REQ-011 The block SHALL have port fade_tick, output, 1 bit: one-cycle pulse that commands the engine to halve all segment brightness.
REQ-012 The block SHALL have port step_pos, output, 3 bits: current sequence position.

Function
REQ-013 speed and direction SHALL be registered once before use (1-cycle latency).
REQ-014 Terminal count tc SHALL be {~speed_r, (STEP_WIDTH-3) ones}, zero-extended to STEP_WIDTH.
REQ-015 The position-to-segment map SHALL be: 0->0, 1->1, 2->6, 3->4, 4->3, 5->2, 6->6, 7->5.
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and ISSUE.
REQ-017 In IDLE: step and fade counters held at 0, fire_valid=0, fade_tick=0, step_pos retained.
REQ-018 IDLE->ISSUE SHALL occur on enable=1, presenting the current step_pos; there is no step delay on the first fire.
REQ-019 In RUN: step counter +1 per cycle; when counter >= tc, the counter SHALL clear to 0, step_pos SHALL move +1 (direction_r=1) or -1 (direction_r=0) mod 8, and the state SHALL go to ISSUE.
REQ-020 The >= compare is required: if tc drops below the current count mid-step, the wrap SHALL occur on the next cycle.
REQ-021 In ISSUE: fire_valid=1 and fire_seg=map[step_pos]; both SHALL stay stable until the cycle where fire_ready=1.
REQ-022 The step counter SHALL be frozen while in ISSUE.
REQ-023 On handshake (fire_valid & fire_ready), next state SHALL be RUN if enable=1, else IDLE.
REQ-024 enable=0 SHALL NOT drop fire_valid before the handshake completes.
REQ-025 enable=0 in RUN SHALL give IDLE on the next edge; step counter cleared, step_pos kept.
REQ-026 Wrap-around: position 7 +1 -> 0; position 0 -1 -> 7.
REQ-027 fade_tick SHALL be high for one cycle each time the free-running fade counter equals all-ones, i.e. once per 2^FADE_WIDTH cycles outside IDLE, in RUN and ISSUE alike.
REQ-028 The fade counter SHALL wrap to 0 after all-ones.
REQ-029 fire_valid, fire_seg and fade_tick SHALL be direct register outputs.
REQ-030 fire_seg SHALL be 0 whenever fire_valid=0.

Reset
REQ-031 Reset low SHALL immediately give: state IDLE, step and fade counters 0, step_pos=0, fire_valid=0, fire_seg=0, fade_tick=0, speed_r=0, direction_r=0.
REQ-032 Reset asserted mid-handshake SHALL abandon the request; no completion is required.
REQ-033 Release SHALL be synchronous-safe: the first active edge after release uses the reset values.

Verification (STEP_WIDTH=6, FADE_WIDTH=4)
REQ-034 Scenario: reset low, then high; enable=1 and fire_ready=1 from the start -> fire_valid pulses with fire_seg=0 first.
REQ-035 Scenario: speed=7, direction=1 -> fire_seg sequence 0,1,6,4,3,2,6,5,0; fires spaced tc+1=8 RUN cycles + 1 ISSUE cycle apart.
REQ-036 Scenario: fire_ready held 0 for 20 cycles in ISSUE -> fire_valid and fire_seg constant, step counter frozen, fade_tick still pulses every 16 cycles.
REQ-037 Scenario: direction=0 from step_pos=0 -> next fire has step_pos=7 and fire_seg=5.
REQ-038 Scenario: enable dropped during ISSUE, fire_ready=1 three cycles later -> fire_valid held until the handshake, then IDLE with step_pos unchanged and no fade_tick.
REQ-039 Scenario: reset asserted asynchronously mid-ISSUE (between edges) -> fire_valid=0 and step_pos=0 without waiting for a clock edge.
